// File: rtl/pipe_ctrl.sv
// pipe_ctrl: per-stage stall generation for the five-stage core (load-use + multi-cycle EX sequencing).
// Optional stall-cycle performance counter built when PIPE_CTRL_PERF_EN is defined.
`default_nettype none

module pipe_ctrl #(
    parameter int MC_CNT_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_id_rreg1_en,
    input  logic [4:0]          i_id_rreg1_addr,
    input  logic                i_id_rreg2_en,
    input  logic [4:0]          i_id_rreg2_addr,
    input  logic                i_ex_is_load,
    input  logic                i_ex_wreg,
    input  logic [4:0]          i_ex_wreg_addr,
    input  logic                i_ex_mc_start,
    input  logic [MC_CNT_W-1:0] i_ex_mc_cycles,
    input  logic                i_flush,
    output logic [5:0]          o_stall,
    output logic                o_mc_busy,
    output logic                o_mc_done,
    output logic [31:0]         o_stall_cycles
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [5:0]          STALL_LU = 6'b000111;
    localparam logic [5:0]          STALL_MC = 6'b001111;
    localparam logic [MC_CNT_W-1:0] CNT_ONE  = MC_CNT_W'(1);
    localparam logic [MC_CNT_W-1:0] CNT_TWO  = MC_CNT_W'(2);

    state_t              state;
    state_t              state_nxt;
    logic [MC_CNT_W-1:0] cnt;
    logic [MC_CNT_W-1:0] cnt_nxt;
    logic                hit1;
    logic                hit2;
    logic                lu;
    logic                mc_long;
    logic                mc_stall;

    always_comb begin
        hit1    = i_id_rreg1_en && (i_id_rreg1_addr == i_ex_wreg_addr);
        hit2    = i_id_rreg2_en && (i_id_rreg2_addr == i_ex_wreg_addr);
        lu      = i_ex_is_load && i_ex_wreg && (i_ex_wreg_addr != 5'd0) && (hit1 || hit2);
        mc_long = (i_ex_mc_cycles >= CNT_TWO);
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mc_stall  = 1'b0;
        o_mc_busy = 1'b0;
        o_mc_done = 1'b0;

        case (state)
            IDLE: begin
                if (i_ex_mc_start) begin
                    if (mc_long) begin
                        mc_stall  = 1'b1;
                        cnt_nxt   = i_ex_mc_cycles - CNT_TWO;
                        state_nxt = (i_ex_mc_cycles == CNT_TWO) ? DONE : BUSY;
                    end else begin
                        // Single-cycle op: result is already valid, no sequence needed.
                        o_mc_done = 1'b1;
                    end
                end
            end
            BUSY: begin
                mc_stall  = 1'b1;
                o_mc_busy = 1'b1;
                cnt_nxt   = cnt - CNT_ONE;
                if (cnt <= CNT_ONE) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                o_mc_done = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        o_stall = (mc_stall ? STALL_MC : 6'b0) | (lu ? STALL_LU : 6'b0);

        if (rst) begin
            o_stall   = 6'b0;
            o_mc_busy = 1'b0;
            o_mc_done = 1'b0;
        end else if (i_flush) begin
            // Flush aborts the sequence outright; the aborted op never reports done.
            o_stall   = 6'b0;
            o_mc_busy = 1'b0;
            o_mc_done = 1'b0;
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= 32'h0;
        end else if (!i_flush && o_stall[0] && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'h1;
        end
    end

    assign o_stall_cycles = stall_cycles;
`else
    assign o_stall_cycles = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed vector table plus randomized run against a cycle-position reference model.
`default_nettype none

module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_id_rreg1_en;
    logic [4:0]  i_id_rreg1_addr;
    logic        i_id_rreg2_en;
    logic [4:0]  i_id_rreg2_addr;
    logic        i_ex_is_load;
    logic        i_ex_wreg;
    logic [4:0]  i_ex_wreg_addr;
    logic        i_ex_mc_start;
    logic [5:0]  i_ex_mc_cycles;
    logic        i_flush;
    logic [5:0]  o_stall;
    logic        o_mc_busy;
    logic        o_mc_done;
    logic [31:0] o_stall_cycles;

    always #5 clk = ~clk;

    pipe_ctrl #(.MC_CNT_W(6)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_id_rreg1_en   (i_id_rreg1_en),
        .i_id_rreg1_addr (i_id_rreg1_addr),
        .i_id_rreg2_en   (i_id_rreg2_en),
        .i_id_rreg2_addr (i_id_rreg2_addr),
        .i_ex_is_load    (i_ex_is_load),
        .i_ex_wreg       (i_ex_wreg),
        .i_ex_wreg_addr  (i_ex_wreg_addr),
        .i_ex_mc_start   (i_ex_mc_start),
        .i_ex_mc_cycles  (i_ex_mc_cycles),
        .i_flush         (i_flush),
        .o_stall         (o_stall),
        .o_mc_busy       (o_mc_busy),
        .o_mc_done       (o_mc_done),
        .o_stall_cycles  (o_stall_cycles)
    );

    typedef struct {
        bit       rst;
        bit       flush;
        bit       start;
        int       n;
        bit       ld;
        bit       wr;
        bit [4:0] wa;
        bit       e1;
        bit [4:0] a1;
        bit       e2;
        bit [4:0] a2;
        bit [5:0] es;
        bit       eb;
        bit       ed;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model: position k within an N-cycle operation.
    bit     m_in_op = 1'b0;
    int     m_k     = 0;
    int     m_n     = 0;
    longint m_perf  = 0;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit r, input bit f, input bit s, input int n,
                                input bit ld, input bit wr, input bit [4:0] wa,
                                input bit e1, input bit [4:0] a1, input bit e2, input bit [4:0] a2,
                                input bit [5:0] es, input bit eb, input bit ed);
        vec_t v;
        v.rst = r; v.flush = f; v.start = s; v.n = n;
        v.ld = ld; v.wr = wr; v.wa = wa; v.e1 = e1; v.a1 = a1; v.e2 = e2; v.a2 = a2;
        v.es = es; v.eb = eb; v.ed = ed;
        return v;
    endfunction

    function automatic vec_t mcv(input bit r, input bit f, input bit s, input int n,
                                 input bit [5:0] es, input bit eb, input bit ed);
        return mk(r, f, s, n, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, es, eb, ed);
    endfunction

    // Applies one cycle: compares the DUT against the model (and the table entry if use_tbl).
    task automatic step(input vec_t v, input bit use_tbl, input string tag);
        bit       lu;
        bit       mc;
        bit [5:0] e_stall;
        bit       e_busy;
        bit       e_done;
        rst             = v.rst;
        i_flush         = v.flush;
        i_ex_mc_start   = v.start;
        i_ex_mc_cycles  = 6'(v.n);
        i_ex_is_load    = v.ld;
        i_ex_wreg       = v.wr;
        i_ex_wreg_addr  = v.wa;
        i_id_rreg1_en   = v.e1;
        i_id_rreg1_addr = v.a1;
        i_id_rreg2_en   = v.e2;
        i_id_rreg2_addr = v.a2;

        e_stall = 6'b0; e_busy = 1'b0; e_done = 1'b0;
        if (!v.rst && !v.flush) begin
            lu = v.ld && v.wr && (v.wa != 0) && ((v.e1 && v.a1 == v.wa) || (v.e2 && v.a2 == v.wa));
            mc = 1'b0;
            if (m_in_op) begin
                mc     = (m_k < m_n - 1);
                e_busy = (m_k >= 1) && (m_k < m_n - 1);
                e_done = (m_k == m_n - 1);
            end else if (v.start) begin
                if (v.n >= 2) mc = 1'b1;
                else e_done = 1'b1;
            end
            e_stall = (mc ? 6'b001111 : 6'b0) | (lu ? 6'b000111 : 6'b0);
        end

        #4;
        check({tag, ".stall"}, 32'(o_stall), 32'(e_stall));
        check({tag, ".busy"}, 32'(o_mc_busy), 32'(e_busy));
        check({tag, ".done"}, 32'(o_mc_done), 32'(e_done));
`ifdef PIPE_CTRL_PERF_EN
        check({tag, ".perf"}, o_stall_cycles, 32'(m_perf));
`else
        check({tag, ".perf"}, o_stall_cycles, 32'h0);
`endif
        if (use_tbl) begin
            check({tag, ".tbl_stall"}, 32'(o_stall), 32'(v.es));
            check({tag, ".tbl_busy"}, 32'(o_mc_busy), 32'(v.eb));
            check({tag, ".tbl_done"}, 32'(o_mc_done), 32'(v.ed));
        end

        @(posedge clk);
        if (v.rst) m_perf = 0;
        else if (!v.flush && e_stall[0] && m_perf < 64'hFFFF_FFFF) m_perf++;
        if (v.rst || v.flush) begin
            m_in_op = 1'b0;
        end else if (m_in_op) begin
            m_k++;
            if (m_k == m_n) m_in_op = 1'b0;
        end else if (v.start && v.n >= 2) begin
            m_in_op = 1'b1;
            m_k     = 1;
            m_n     = v.n;
        end
        #1;
    endtask

    initial begin
        vec_t v;
        // Reset and idle
        tbl.push_back(mcv(1, 0, 0, 0, 6'b000000, 0, 0));
        tbl.push_back(mcv(1, 0, 1, 4, 6'b000000, 0, 0));
        tbl.push_back(mcv(0, 0, 0, 0, 6'b000000, 0, 0));
        // Load-use via rreg1 r5, then the load leaves EX
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 5'd5, 1, 5'd5, 0, 5'd0, 6'b000111, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 5'd0, 1, 5'd5, 0, 5'd0, 6'b000000, 0, 0));
        // Destination r0 never hazards; disabled read port does not hazard
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 5'd0, 1, 5'd0, 1, 5'd0, 6'b000000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 5'd7, 0, 5'd3, 1, 5'd7, 6'b000111, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 5'd7, 0, 5'd7, 0, 5'd7, 6'b000000, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 5'd7, 1, 5'd7, 0, 5'd0, 6'b000000, 0, 0));
        // N = 4
        tbl.push_back(mcv(0, 0, 1, 4, 6'b001111, 0, 0));
        tbl.push_back(mcv(0, 0, 1, 4, 6'b001111, 1, 0));
        tbl.push_back(mcv(0, 0, 1, 4, 6'b001111, 1, 0));
        tbl.push_back(mcv(0, 0, 1, 4, 6'b000000, 0, 1));
        tbl.push_back(mcv(0, 0, 0, 0, 6'b000000, 0, 0));
        // N = 2, back-to-back N = 2
        tbl.push_back(mcv(0, 0, 1, 2, 6'b001111, 0, 0));
        tbl.push_back(mcv(0, 0, 1, 2, 6'b000000, 0, 1));
        tbl.push_back(mcv(0, 0, 1, 2, 6'b001111, 0, 0));
        tbl.push_back(mcv(0, 0, 1, 2, 6'b000000, 0, 1));
        tbl.push_back(mcv(0, 0, 0, 0, 6'b000000, 0, 0));
        // N = 1 and N = 0
        tbl.push_back(mcv(0, 0, 1, 1, 6'b000000, 0, 1));
        tbl.push_back(mcv(0, 0, 1, 0, 6'b000000, 0, 1));
        tbl.push_back(mcv(0, 0, 0, 0, 6'b000000, 0, 0));
        // N = 10 flushed on cycle 3
        tbl.push_back(mcv(0, 0, 1, 10, 6'b001111, 0, 0));
        tbl.push_back(mcv(0, 0, 1, 10, 6'b001111, 1, 0));
        tbl.push_back(mcv(0, 0, 1, 10, 6'b001111, 1, 0));
        tbl.push_back(mcv(0, 1, 1, 10, 6'b000000, 0, 0));
        tbl.push_back(mcv(0, 0, 0, 0, 6'b000000, 0, 0));
        tbl.push_back(mcv(0, 0, 0, 0, 6'b000000, 0, 0));
        // N = 10 reset on cycle 3
        tbl.push_back(mcv(0, 0, 1, 10, 6'b001111, 0, 0));
        tbl.push_back(mcv(0, 0, 1, 10, 6'b001111, 1, 0));
        tbl.push_back(mcv(0, 0, 1, 10, 6'b001111, 1, 0));
        tbl.push_back(mcv(1, 0, 1, 10, 6'b000000, 0, 0));
        tbl.push_back(mcv(0, 0, 0, 0, 6'b000000, 0, 0));
        // N = 3 overlapping a load-use hazard; flush masks a hazard
        tbl.push_back(mk(0, 0, 1, 3, 1, 1, 5'd9, 1, 5'd9, 0, 5'd0, 6'b001111, 0, 0));
        tbl.push_back(mk(0, 0, 1, 3, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 6'b001111, 1, 0));
        tbl.push_back(mk(0, 0, 1, 3, 1, 1, 5'd9, 0, 5'd0, 1, 5'd9, 6'b000111, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 1, 1, 5'd9, 1, 5'd9, 0, 5'd0, 6'b000000, 0, 0));
        tbl.push_back(mcv(0, 0, 0, 0, 6'b000000, 0, 0));

        rst = 1'b1;
        i_flush = 1'b0; i_ex_mc_start = 1'b0; i_ex_mc_cycles = 6'd0;
        i_ex_is_load = 1'b0; i_ex_wreg = 1'b0; i_ex_wreg_addr = 5'd0;
        i_id_rreg1_en = 1'b0; i_id_rreg1_addr = 5'd0; i_id_rreg2_en = 1'b0; i_id_rreg2_addr = 5'd0;
        @(posedge clk);
        #1;

        // Perf: 3 multi-cycle stall cycles plus one load-use stall
        step(mcv(1, 0, 0, 0, 6'b0, 0, 0), 1'b1, "perf_rst");
        for (int i = 0; i < 4; i++) step(mcv(0, 0, 1, 4, 6'b0, 0, 0), 1'b0, "perf_mc");
        step(mk(0, 0, 0, 0, 1, 1, 5'd5, 1, 5'd5, 0, 5'd0, 6'b000111, 0, 0), 1'b1, "perf_lu");
        step(mcv(0, 0, 0, 0, 6'b0, 0, 0), 1'b1, "perf_idle");
`ifdef PIPE_CTRL_PERF_EN
        check("perf_total", o_stall_cycles, 32'd4);
`else
        check("perf_total", o_stall_cycles, 32'd0);
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], 1'b1, $sformatf("tbl%0d", i));
        end

        for (int i = 0; i < 3000; i++) begin
            v.rst   = ($urandom_range(0, 199) == 0);
            v.flush = ($urandom_range(0, 39) == 0);
            v.start = m_in_op ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 4) == 0);
            v.n     = m_in_op ? m_n : $urandom_range(0, 9);
            v.ld    = $urandom_range(0, 1);
            v.wr    = $urandom_range(0, 3) != 0;
            v.wa    = 5'($urandom_range(0, 3));
            v.e1    = $urandom_range(0, 1);
            v.a1    = 5'($urandom_range(0, 3));
            v.e2    = $urandom_range(0, 1);
            v.a2    = 5'($urandom_range(0, 3));
            v.es = 6'b0; v.eb = 1'b0; v.ed = 1'b0;
            step(v, 1'b0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage MIPS core. Generates the per-stage stall vector from two sources: load-use hazards detected between the decode stage's register read requests and a load in EX, and multi-cycle EX operations (multiply-accumulate, divide) sequenced by an internal counter FSM. Sits beside the pipeline registers; every pipeline register and the PC consume one bit of `o_stall`.

## Interface
Parameters:
- `MC_CNT_W`, 6, width of the multi-cycle length field and internal counter.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- `clk` input 1: clock, rising edge.
- `rst` input 1: synchronous active-high reset.
- `i_id_rreg1_en` input 1: decode reads source register 1.
- `i_id_rreg1_addr` input 5: decode source register 1 address.
- `i_id_rreg2_en` input 1: decode reads source register 2.
- `i_id_rreg2_addr` input 5: decode source register 2 address.
- `i_ex_is_load` input 1: instruction in EX is a load.
- `i_ex_wreg` input 1: instruction in EX writes a register.
- `i_ex_wreg_addr` input 5: EX destination register.
- `i_ex_mc_start` input 1: instruction in EX is multi-cycle.
- `i_ex_mc_cycles` input MC_CNT_W: total EX cycles N required by that instruction.
- `i_flush` input 1: exception/redirect flush; aborts any multi-cycle sequence.
- `o_stall` output 6: hold bits {wb, mem, ex, id, if, pc}; bit 0 = PC.
- `o_mc_busy` output 1: multi-cycle sequence in progress.
- `o_mc_done` output 1: EX multi-cycle result valid this cycle; EX may advance.
- `o_stall_cycles` output 32: performance counter (see Configuration).

## Operation
- FSM states: IDLE, BUSY, DONE. Counter `cnt` is MC_CNT_W bits.
- Load-use hazard `lu` (combinational): `i_ex_is_load & i_ex_wreg & (i_ex_wreg_addr != 0) & ((i_id_rreg1_en & i_id_rreg1_addr == i_ex_wreg_addr) | (i_id_rreg2_en & i_id_rreg2_addr == i_ex_wreg_addr))`. When `lu` is set: `o_stall = 6'b000111`, meaning PC, IF and ID hold and a bubble enters EX.
- IDLE, with `i_ex_mc_start` and N ≥ 2: `o_stall = 6'b001111` this cycle, `cnt <= N-2`, next state is DONE if N == 2, otherwise BUSY.
- IDLE, with `i_ex_mc_start` and N ∈ {0,1}: no stall, `o_mc_done = 1` in the same cycle, state stays IDLE.
- BUSY: `o_stall = 6'b001111`, `o_mc_busy = 1`, `cnt <= cnt-1`. When `cnt == 1`, next state is DONE.
- DONE: `o_stall = 0` (unless `lu`), `o_mc_done = 1`, `o_mc_busy = 0`. Next state is IDLE.
- `i_ex_mc_start` is ignored in BUSY and DONE, because the held instruction keeps asserting it.
- Total stalled cycles for an N-cycle operation: N-1. Result is ready on cycle N.
- Priority: `o_stall` is the bitwise OR of the multi-cycle vector and the load-use vector. The effective result is 001111 whenever the multi-cycle vector is active.
- `i_flush`: forces `o_stall = 0` and `o_mc_done = 0` in the same cycle, and sets next state to IDLE with `cnt <= 0`. It overrides every other condition except `rst`.
- Register address 0 never causes a hazard.

## Timing
- Reset values: state IDLE, `cnt` 0, `o_stall` 0, `o_mc_busy` 0, `o_mc_done` 0, `o_stall_cycles` 0. `rst` also forces all combinational outputs to 0 while asserted.
- `o_stall`, `o_mc_done` and `o_mc_busy` are combinational from state and inputs (zero-cycle latency). State and `cnt` update on the rising edge of `clk`.
- Reset asserted mid-sequence: the FSM is in IDLE at the next edge, and no `o_mc_done` is issued for the aborted operation.
- Load-use stall lasts exactly 1 cycle. On the next edge the load has left EX, so `lu` drops unless a new hazard appears.
- Back-to-back multi-cycle ops: DONE → IDLE, and the next op starts in the following cycle, giving one non-stall cycle between the two sequences.

## Configuration
- `PIPE_CTRL_PERF_EN` defined: `o_stall_cycles` increments every cycle in which `o_stall[0] == 1`.
  - It saturates at 32'hFFFFFFFF.
  - It clears on `rst`.
  - It does not increment while `i_flush` is high.
- `PIPE_CTRL_PERF_EN` undefined: the counter is not built, and `o_stall_cycles` is tied to 32'h0. The port list is unchanged.

## Test plan
- Load-use: EX = load to r5, ID reads rreg1 = r5 with en = 1 → `o_stall = 000111` for 1 cycle, then 0. Same case with dest r0 → no stall.
- Multi-cycle N = 4: `i_ex_mc_start = 1` from cycle 0 → `o_stall = 001111` on cycles 0–2; `o_mc_busy` = 1 on cycles 1–2; `o_mc_done = 1`, `o_stall = 0` on cycle 3; IDLE on cycle 4.
- N = 2 and N = 1: N = 2 → stall on cycle 0 only, done on cycle 1. N = 1 → done on cycle 0 with no stall.
- Flush during BUSY (N = 10, `i_flush` on cycle 3) → `o_stall = 0` on cycle 3, IDLE on cycle 4, no `o_mc_done` pulse. The same sequence with `rst` on cycle 3 → all outputs 0 on cycle 4.
- Perf (macro defined): a 3-cycle multi-cycle stall plus 1 load-use stall → `o_stall_cycles = 4`. Macro undefined → stays 0.
